// File: rtl/pixel_ray_sequencer_if.sv
// pixel_ray_sequencer_if: ray output handshake between the sequencer and its consumer
interface pixel_ray_sequencer_if #(
  parameter int FRAC = 16,
  parameter int IDX_W = 10
);
  logic valid;
  logic ready;
  logic last;
  logic signed [FRAC+2:0] dir_x;
  logic signed [FRAC+2:0] dir_y;
  logic signed [FRAC+2:0] dir_z;
  logic [IDX_W-1:0] px;
  logic [IDX_W-1:0] py;
  logic [3:0] sample;
  modport master (output valid, last, dir_x, dir_y, dir_z, px, py, sample, input ready);
  modport slave (input valid, last, dir_x, dir_y, dir_z, px, py, sample, output ready);
endinterface

// File: rtl/pixel_ray_sequencer.sv
// pixel_ray_sequencer: scans samples/pixels of a frame and emits camera-space primary rays through a 4-stage pipeline
module pixel_ray_sequencer #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int SPP = 1,
  parameter int FRAC = 16,
  parameter int unsigned SCALE_X = 193,
  parameter int unsigned SCALE_Y = 193,
  parameter int unsigned SHIFT_X = 77321,
  parameter int unsigned SHIFT_Y = 57991,
  parameter bit JITTER = 1'b1,
  parameter logic [15:0] SEED_X = 16'h1ACE,
  parameter logic [15:0] SEED_Y = 16'hC0DE
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic frame_done,
  pixel_ray_sequencer_if.master ray
);
  localparam int IDX_W = 10;
  localparam int DW = FRAC + 3;
  localparam int CW = IDX_W + FRAC;
  localparam int PW = CW + 32;
  localparam logic [FRAC-1:0] HALF = FRAC'(1) << (FRAC - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] px;
    logic [IDX_W-1:0] py;
    logic [3:0] s;
    logic l;
  } meta_t;
  state_t state;
  logic [IDX_W-1:0] px_c, py_c;
  logic [3:0] s_c;
  logic [15:0] prng_x, prng_y;
  logic v1, v2, v3;
  meta_t m1, m2, m3;
  logic [CW-1:0] cx1, cy1;
  logic [PW-1:0] prx2, pry2;
  logic [DW-1:0] dx3, dy3;
  logic end_s, end_px, end_py, end_all, adv, issue;
  logic [FRAC-1:0] off_x, off_y;
  function automatic logic [15:0] xorshift(input logic [15:0] v);
    logic [15:0] x;
    x = v ^ (v << 7);
    x = x ^ (x >> 9);
    return x ^ (x << 8);
  endfunction
  always_comb begin
    end_s = s_c == 4'(SPP - 1);
    end_px = px_c == IDX_W'(H_RES - 1);
    end_py = py_c == IDX_W'(V_RES - 1);
    end_all = end_s && end_px && end_py;
    adv = !ray.valid || ray.ready;
    issue = state == RUN && adv && !abort;
    off_x = JITTER ? prng_x[15 -: FRAC] : HALF;
    off_y = JITTER ? prng_y[15 -: FRAC] : HALF;
  end
  assign busy = state != IDLE;
  assign ray.dir_z = DW'(-(1 << FRAC));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {px_c, py_c, s_c} <= '0;
      prng_x <= SEED_X;
      prng_y <= SEED_Y;
      {v1, v2, v3, frame_done} <= '0;
      {m1, m2, m3, cx1, cy1, prx2, pry2, dx3, dy3} <= '0;
      ray.valid <= 1'b0;
      ray.last <= 1'b0;
      ray.px <= '0;
      ray.py <= '0;
      ray.sample <= '0;
      ray.dir_x <= '0;
      ray.dir_y <= '0;
    end else begin
      frame_done <= 1'b0;
      if (adv) begin
        v1 <= issue;
        m1 <= {px_c, py_c, s_c, end_all};
        cx1 <= {px_c, off_x};
        cy1 <= {py_c, off_y};
        v2 <= v1;
        m2 <= m1;
        prx2 <= PW'(cx1) * PW'(SCALE_X);
        pry2 <= PW'(cy1) * PW'(SCALE_Y);
        v3 <= v2;
        m3 <= m2;
        dx3 <= DW'((prx2 >> FRAC) - PW'(SHIFT_X));
        dy3 <= DW'((pry2 >> FRAC) - PW'(SHIFT_Y));
        ray.valid <= v3;
        ray.px <= m3.px;
        ray.py <= m3.py;
        ray.sample <= m3.s;
        ray.last <= m3.l;
        ray.dir_x <= dx3;
        ray.dir_y <= dy3;
      end
      if (issue) begin
        s_c <= end_s ? '0 : s_c + 4'd1;
        if (end_s) px_c <= end_px ? '0 : px_c + IDX_W'(1);
        if (end_s && end_px) py_c <= end_py ? '0 : py_c + IDX_W'(1);
        prng_x <= xorshift(prng_x);
        prng_y <= xorshift(prng_y);
      end
      case (state)
        IDLE: if (start && !frame_done && !abort) begin
          state <= RUN;
          {px_c, py_c, s_c} <= '0;
        end
        RUN: if (issue && end_all) state <= DRAIN;
        DRAIN: if (ray.valid && ray.ready && ray.last && !abort) begin
          state <= IDLE;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // abort wins over everything else; PRNG state deliberately survives it
      if (abort) begin
        state <= IDLE;
        {v1, v2, v3} <= '0;
        ray.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_ray_sequencer.sv
// tb_pixel_ray_sequencer: scoreboard model of the ray sequence plus directed frame, stall, abort and reset checks
module tb_pixel_ray_sequencer;
  localparam int AH = 5, AV = 3, AS = 3, AN = AH * AV * AS;
  typedef struct {
    int px;
    int py;
    int s;
    bit l;
    longint dx;
    longint dy;
  } ray_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, busy_a, fd_a;
  logic start_b = 1'b0, busy_b, fd_b;
  logic start_c = 1'b0, busy_c, fd_c;
  logic abort_off = 1'b0;
  int errors = 0, checks = 0;
  ray_t q[$];
  bit m_busy = 0, m_run = 0, m_fd = 0;
  int m_n = 0;
  logic [15:0] mx = 16'h1ACE, my = 16'hC0DE;
  pixel_ray_sequencer_if #(.FRAC(16), .IDX_W(10)) ra();
  pixel_ray_sequencer_if #(.FRAC(16), .IDX_W(10)) rb();
  pixel_ray_sequencer_if #(.FRAC(16), .IDX_W(10)) rc();
  pixel_ray_sequencer #(.H_RES(AH), .V_RES(AV), .SPP(AS)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .frame_done(fd_a), .ray(ra));
  pixel_ray_sequencer #(.H_RES(4), .V_RES(2), .SPP(2), .JITTER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_off), .busy(busy_b), .frame_done(fd_b), .ray(rb));
  pixel_ray_sequencer #(.H_RES(1), .V_RES(1), .SPP(1), .JITTER(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_off), .busy(busy_c), .frame_done(fd_c), .ray(rc));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] xs(input logic [15:0] v);
    int x = int'(v);
    x = (x ^ (x * 128)) % 65536;
    x = x ^ (x / 512);
    x = (x ^ (x * 256)) % 65536;
    return 16'(x);
  endfunction
  function automatic longint dirv(input int pix, input int off, input longint shift);
    return ((longint'(pix) * 65536 + longint'(off)) * 193) / 65536 - shift;
  endfunction
  function automatic ray_t mk(input int n, input int ox, input int oy);
    ray_t r;
    r.s = n % AS;
    r.px = (n / AS) % AH;
    r.py = n / (AS * AH);
    r.l = n == AN - 1;
    r.dx = dirv(r.px, ox, 77321);
    r.dy = dirv(r.py, oy, 57991);
    return r;
  endfunction
  always @(negedge clk) begin : model
    bit hs, adv, acc, nfd;
    ray_t r;
    if (!rst) begin
      chk("a_busy", busy_a, m_busy);
      chk("a_frame_done", fd_a, m_fd);
      if (ra.valid) begin
        if (q.size() == 0) chk("a_spurious_valid", ra.valid, 0);
        else begin
          chk("a_px", ra.px, q[0].px);
          chk("a_py", ra.py, q[0].py);
          chk("a_sample", ra.sample, q[0].s);
          chk("a_last", ra.last, q[0].l);
          chk("a_dir_x", ra.dir_x, q[0].dx);
          chk("a_dir_y", ra.dir_y, q[0].dy);
          chk("a_dir_z", ra.dir_z, -65536);
        end
      end
    end
    hs = ra.valid && ra.ready;
    adv = !ra.valid || ra.ready;
    acc = start_a && !m_busy && !m_fd && !abort_a;
    if (rst) begin
      q.delete();
      {m_busy, m_run, m_fd} = '0;
      mx = 16'h1ACE;
      my = 16'hC0DE;
    end else if (abort_a) begin
      q.delete();
      {m_busy, m_run, m_fd} = '0;
    end else begin
      nfd = 0;
      if (hs && q.size() > 0) begin
        r = q.pop_front();
        if (r.l) begin
          m_busy = 0;
          nfd = 1;
        end
      end
      if (m_run && adv) begin
        q.push_back(mk(m_n, int'(mx), int'(my)));
        mx = xs(mx);
        my = xs(my);
        m_n++;
        if (m_n == AN) m_run = 0;
      end
      if (acc) begin
        m_busy = 1;
        m_run = 1;
        m_n = 0;
      end
      m_fd = nfd;
    end
  end
  initial begin
    int t;
    ra.ready = 1'b1;
    rb.ready = 1'b1;
    rc.ready = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", ra.valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_last", ra.last, 0);
    chk("rst_px", ra.px, 0);
    chk("rst_dir_x", ra.dir_x, 0);
    rst = 1'b0;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    repeat (3) cyc();
    chk("b_not_yet_valid", rb.valid, 0);
    cyc();
    chk("b_first_valid", rb.valid, 1);
    chk("b_first_dir_x", rb.dir_x, -77225);
    for (int k = 0; k < 16; k++) begin
      chk("b_valid", rb.valid, 1);
      chk("b_px", rb.px, (k / 2) % 4);
      chk("b_py", rb.py, k / 8);
      chk("b_sample", rb.sample, k % 2);
      chk("b_last", rb.last, k == 15);
      chk("b_dir_x", rb.dir_x, dirv((k / 2) % 4, 32768, 77321));
      chk("b_dir_y", rb.dir_y, dirv(k / 8, 32768, 57991));
      cyc();
    end
    chk("b_frame_done", fd_b, 1);
    chk("b_valid_after", rb.valid, 0);
    cyc();
    chk("b_frame_done_pulse", fd_b, 0);
    chk("b_busy_after", busy_b, 0);
    start_c = 1'b1;
    cyc();
    start_c = 1'b0;
    t = 0;
    while (!rc.valid && t < 20) begin cyc(); t++; end
    chk("c_valid", rc.valid, 1);
    chk("c_last", rc.last, 1);
    chk("c_px", rc.px, 0);
    chk("c_py", rc.py, 0);
    chk("c_sample", rc.sample, 0);
    cyc();
    chk("c_frame_done", fd_c, 1);
    chk("c_valid_after", rc.valid, 0);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    t = 0;
    while (!ra.valid && t < 20) begin cyc(); t++; end
    chk("a_first_dir_x", ra.dir_x, -77301);
    chk("a_first_dir_y", ra.dir_y, -57846);
    cyc();
    chk("a_second_dir_x", ra.dir_x, -77214);
    chk("a_second_sample", ra.sample, 1);
    t = 0;
    while (!fd_a && t < 300) begin cyc(); t++; end
    chk("a_frame1_done", fd_a, 1);
    cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (12) cyc();
    ra.ready = 1'b0;
    repeat (10) cyc();
    ra.ready = 1'b1;
    t = 0;
    while (!fd_a && t < 300) begin cyc(); t++; end
    chk("a_stall_frame_done", fd_a, 1);
    cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    t = 0;
    while (m_n < 5 && t < 50) begin cyc(); t++; end
    abort_a = 1'b1;
    cyc();
    abort_a = 1'b0;
    chk("abort_valid", ra.valid, 0);
    chk("abort_busy", busy_a, 0);
    repeat (6) cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    t = 0;
    while (!ra.valid && t < 20) begin cyc(); t++; end
    chk("restart_px", ra.px, 0);
    chk("restart_py", ra.py, 0);
    chk("restart_sample", ra.sample, 0);
    t = 0;
    while (!(m_busy && !m_run) && t < 300) begin cyc(); t++; end
    rst = 1'b1;
    cyc();
    chk("drain_rst_valid", ra.valid, 0);
    chk("drain_rst_busy", busy_a, 0);
    chk("drain_rst_last", ra.last, 0);
    chk("drain_rst_dir_y", ra.dir_y, 0);
    rst = 1'b0;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    t = 0;
    while (!ra.valid && t < 20) begin cyc(); t++; end
    chk("reseed_dir_x", ra.dir_x, -77301);
    chk("reseed_dir_y", ra.dir_y, -57846);
    for (int i = 0; i < 2500; i++) begin
      ra.ready = $urandom_range(0, 9) < 7;
      start_a = $urandom_range(0, 19) == 0;
      abort_a = $urandom_range(0, 199) == 0;
      rst = $urandom_range(0, 499) == 0;
      cyc();
    end
    {start_a, abort_a, rst} = '0;
    ra.ready = 1'b1;
    repeat (20) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
